mem_test_engine: RTL

MEM_TEST_ENGINE -- requirements
Module: mem_test_engine

---
 rtl/mem_test_engine_pkg.sv | 16 +
 rtl/mem_test_engine_if.sv | 23 ++
 rtl/mem_test_pipe.sv | 43 ++++
 rtl/mem_test_engine.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mem_test_engine_pkg.sv
// Shared types and default widths for the memory test engine
// and the data_memory it exercises.
package mem_test_engine_pkg;

    localparam int MEM_ADDR_W = 48;
    localparam int MEM_DATA_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/mem_test_engine_if.sv
// data_memory request/response bus; the engine is master.
interface mem_test_engine_if
    import mem_test_engine_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    logic              memWrite;
    logic              memRead;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;

    modport master (
        output memWrite, memRead, address, writeData,
        input  readData
    );

    modport slave (
        input  memWrite, memRead, address, writeData,
        output readData
    );
endinterface

// File: rtl/mem_test_pipe.sv
// Delay line carrying each read's address and expected pattern
// until its readData returns.
module mem_test_pipe #(
    parameter int DEPTH  = 1,
    parameter int ADDR_W = 48,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);
    logic [DEPTH-1:0]  vld;
    logic [ADDR_W-1:0] adr [DEPTH];
    logic [DATA_W-1:0] dat [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                adr[i] <= '0;
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            adr[0] <= in_addr;
            dat[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                adr[i] <= adr[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_addr  = adr[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
endmodule

// File: rtl/mem_test_engine.sv
// Write-then-read-back memory tester: writes an incrementing
// pattern over a strided range, reads it back and counts mismatches.
module mem_test_engine
    import mem_test_engine_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       num_words,
    input  logic [7:0]        stride,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] fail_addr,
    mem_test_engine_if.master mem
);
    state_t            state, nstate;
    logic [ADDR_W-1:0] base_q, cur_addr;
    logic [DATA_W-1:0] seed_q, cur_data;
    logic [15:0]       n_q, idx, err_nxt;
    logic [7:0]        stride_q;
    logic [2:0]        drain_cnt;
    logic              accept, last, mismatch;
    logic              p_valid;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_data;

    assign accept   = (state == S_IDLE) && start;
    assign last     = (idx == n_q - 16'd1);
    assign mismatch = p_valid && (mem.readData != p_data);

    always_comb begin
        err_nxt = err_count;
        if (accept)
            err_nxt = '0;
        else if (mismatch && err_count != 16'hFFFF)
            err_nxt = err_count + 16'd1;
    end

    always_comb begin
        nstate        = state;
        busy          = 1'b0;
        done          = 1'b0;
        mem.memWrite  = 1'b0;
        mem.memRead   = 1'b0;
        mem.address   = '0;
        mem.writeData = '0;
        unique case (state)
            S_IDLE: begin
                if (start)
                    nstate = (num_words == 16'd0) ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                busy          = 1'b1;
                mem.memWrite  = 1'b1;
                mem.address   = cur_addr;
                mem.writeData = cur_data;
                if (last) nstate = S_READ;
            end
            S_READ: begin
                busy        = 1'b1;
                mem.memRead = 1'b1;
                mem.address = cur_addr;
                if (last) nstate = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 3'(READ_LAT - 1)) nstate = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                nstate = S_IDLE;
            end
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nstate;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q    <= '0;
            seed_q    <= '0;
            n_q       <= '0;
            stride_q  <= '0;
            cur_addr  <= '0;
            cur_data  <= '0;
            idx       <= '0;
            drain_cnt <= '0;
            err_count <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else begin
            err_count <= err_nxt;
            if (accept) begin
                base_q    <= base_addr;
                seed_q    <= seed;
                n_q       <= num_words;
                stride_q  <= stride;
                cur_addr  <= base_addr;
                cur_data  <= seed;
                idx       <= '0;
                drain_cnt <= '0;
                fail_addr <= '0;
                pass      <= 1'b0;
            end else if (state == S_WRITE || state == S_READ) begin
                // rewind so the read pass replays the same sequence
                if (last) begin
                    idx      <= '0;
                    cur_addr <= base_q;
                    cur_data <= seed_q;
                end else begin
                    idx      <= idx + 16'd1;
                    cur_addr <= cur_addr + ADDR_W'(stride_q);
                    cur_data <= cur_data + DATA_W'(1);
                end
            end
            if (state == S_DRAIN) drain_cnt <= drain_cnt + 3'd1;
            if (mismatch && err_count == 16'd0) fail_addr <= p_addr;
            if (nstate == S_DONE) pass <= (err_nxt == 16'd0);
        end
    end

    mem_test_pipe #(
        .DEPTH  (READ_LAT),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (state == S_READ),
        .in_addr   (cur_addr),
        .in_data   (cur_data),
        .out_valid (p_valid),
        .out_addr  (p_addr),
        .out_data  (p_data)
    );
endmodule
